// File: rtl/conv_deinterleaver.sv
// conv_deinterleaver: byte-wide convolutional deinterleaver (I branches, branch j delays (I-1-j)*M visits).
// Optional: define CONV_DEINT_PRIME_GATE_EN to hold out_valid low until the delay lines are primed.
// Storage is one shared RAM with a circular pointer per branch; a per-branch "full" flag
// makes cells that have not been written since reset read as zero, so the RAM needs no reset.
module conv_deinterleaver #(
    parameter int DATA_W     = 8,
    parameter int BRANCHES   = 12,
    parameter int DEPTH_UNIT = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sync,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_branch,
    output logic              sync_err
);
    localparam int MAX_D = (BRANCHES - 1) * DEPTH_UNIT;
    localparam int TOTAL = DEPTH_UNIT * BRANCHES * (BRANCHES - 1) / 2;
    localparam int PRIME = MAX_D * BRANCHES;
    localparam int BW    = $clog2(BRANCHES);
    localparam int AW    = $clog2(TOTAL);
    localparam int PW    = MAX_D > 1 ? $clog2(MAX_D) : 1;

    logic [BW-1:0]     b_q, b_d, sel;
    logic [PW-1:0]     ptr_q [BRANCHES];
    logic [PW-1:0]     ptr_d [BRANCHES];
    logic [BRANCHES-1:0] full_q, full_d;
    logic [DATA_W-1:0] mem [TOTAL];
    logic [AW-1:0]     addr;
    logic [PW-1:0]     last;
    logic              zero_d;
    logic              primed;
    logic [DATA_W-1:0] rd;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [3:0]        out_branch_q, out_branch_d;
    logic              sync_err_q, sync_err_d;
    int                sel_i;

`ifdef CONV_DEINT_PRIME_GATE_EN
    localparam int CW = $clog2(PRIME + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Saturating count of accepted bytes; only reset clears it
    always_comb begin
        primed = (cnt_q == CW'(PRIME));
        cnt_d  = (in_valid && !primed) ? cnt_q + 1'b1 : cnt_q;
    end

    // Prime counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign primed = 1'b1;
`endif

    // Commutator, branch addressing and next-state for pointers, fill flags and outputs
    always_comb begin
        sel    = (in_sync && b_q != '0) ? '0 : b_q;
        sel_i  = int'(sel);
        zero_d = (sel_i == BRANCHES - 1);
        last   = PW'((BRANCHES - 1 - sel_i) * DEPTH_UNIT - 1);
        addr   = AW'(sel_i * MAX_D - DEPTH_UNIT * sel_i * (sel_i - 1) / 2 + int'(ptr_q[sel]));
        rd     = zero_d ? in_data : (full_q[sel] ? mem[addr] : '0);
        ptr_d  = ptr_q;
        full_d = full_q;
        if (in_valid && !zero_d) begin
            ptr_d[sel]  = (ptr_q[sel] == last) ? '0 : ptr_q[sel] + 1'b1;
            full_d[sel] = full_q[sel] | (ptr_q[sel] == last);
        end
        b_d          = in_valid ? (zero_d ? '0 : sel + 1'b1) : b_q;
        sync_err_d   = in_valid && in_sync && (b_q != '0);
        out_valid_d  = in_valid && primed;
        out_data_d   = in_valid ? rd : out_data_q;
        out_branch_d = in_valid ? 4'(sel) : out_branch_q;
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_q          <= '0;
            full_q       <= '0;
            for (int i = 0; i < BRANCHES; i++) ptr_q[i] <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_branch_q <= '0;
            sync_err_q   <= 1'b0;
        end else begin
            b_q          <= b_d;
            full_q       <= full_d;
            ptr_q        <= ptr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_branch_q <= out_branch_d;
            sync_err_q   <= sync_err_d;
        end
    end

    // Delay-line RAM: the newest byte overwrites the cell just read out
    always_ff @(posedge clk) begin
        if (in_valid && !zero_d) mem[addr] <= in_data;
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_branch = out_branch_q;
    assign sync_err   = sync_err_q;
endmodule

// File: doc/conv_deinterleaver.md
Name: conv_deinterleaver

Overview:
- Byte-wide convolutional deinterleaver that undoes the interleaver's per-branch delay lines on the receive side.
- Input bytes are distributed by a commutator over BRANCHES branches. Branch j delays by (BRANCHES-1-j)*DEPTH_UNIT branch visits, which is the complement of the interleaver's j*DEPTH_UNIT.
- It sits between the channel/sync-detect stage and the outer decoder. It restores the original byte order with a fixed end-to-end latency.

Parameters:
- DATA_W, 8, byte width.
- BRANCHES, 12, number of commutator branches (I).
- DEPTH_UNIT, 17, delay-cell increment per branch (M).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is accepted this cycle.
- in_data  input  DATA_W  interleaved byte.
- in_sync  input  1  marks a byte that must land on branch 0 (e.g. sync byte 0x47); sampled only with in_valid.
- out_valid  output  1  out_data valid this cycle.
- out_data  output  DATA_W  deinterleaved byte.
- out_branch  output  4  branch index the output byte came from.
- sync_err  output  1  one-cycle pulse: in_sync arrived while the commutator was not at branch 0.

Behaviour:
Reset (reset low, asynchronous):
- Branch counter = 0.
- All delay cells = 0.
- Outputs: out_valid = 0, out_data = 0, out_branch = 0, sync_err = 0.

Commutator:
- Branch counter b advances only on an accepted byte (in_valid = 1).
- It counts 0 → 1 → … → BRANCHES-1 → 0, wrapping.
- When in_valid = 0: nothing shifts, and b holds.

Sync alignment:
- If in_valid = 1, in_sync = 1 and b != 0: the byte is routed to branch 0 and b becomes 1 for the next byte.
- sync_err pulses the following cycle.
- Stored cells are not flushed.
- If in_sync = 1 and b = 0: normal operation, no error.

Branch storage:
- Branch j is a shift chain of D_j = (BRANCHES-1-j)*DEPTH_UNIT cells of DATA_W bits. With defaults this is 187 cells for j=0 down to 0 cells for j=11; total 1122 cells.
- On an accepted byte for branch j with D_j > 0:
  - the output is the oldest cell;
  - the chain shifts by one;
  - in_data enters the newest cell.
- All of this happens in the same clock edge.
- For D_j = 0, the output is in_data itself.
- Storage may be a flop chain or a RAM with per-branch circular read/write pointers. Either way the data behaviour is identical, and reset contents read as 0.

Output timing:
- Fixed 1-cycle latency: out_valid(t+1) = in_valid(t).
- out_data and out_branch are registered alongside out_valid.
- When out_valid = 0, out_data holds its last value.

End-to-end latency:
- Interleaver plus deinterleaver delay every byte by (BRANCHES-1)*DEPTH_UNIT*BRANCHES accepted bytes (2244 with defaults).
- The deinterleaver alone adds no extra pipeline delay beyond the 1-cycle output register.

Boundary conditions:
- Back-to-back in_valid is supported at 1 byte/clock.
- Arbitrary gaps in in_valid are allowed.
- Reset asserted mid-stream clears all state immediately; the first accepted byte after release goes to branch 0.

Optional Feature:
Macro name: CONV_DEINT_PRIME_GATE_EN.
- Defined:
  - a counter (saturating at 2244 with defaults) counts accepted bytes;
  - out_valid is forced 0 until (BRANCHES-1)*DEPTH_UNIT*BRANCHES bytes have been accepted, so the zero fill of the delay lines is never presented downstream;
  - reset clears the counter;
  - a sync_err does not clear it.
- Not defined: out_valid always follows in_valid with 1-cycle latency, and initial outputs from unfilled branches are 0.

Test Plan:
- Zero-delay branch: after reset, feed 11 bytes with in_valid = 1 continuously, then 0xA5 on branch 11 → out_valid = 1, out_data = 0xA5, out_branch = 11 one cycle later.
- Branch 10 delay: feed 0x3C at branch 10 visit 0, then continuous bytes → 0x3C appears at out_branch = 10 after exactly 17 further visits to branch 10 (204 accepted bytes later); earlier branch-10 outputs are 0x00.
- Loopback: reference interleaver model (I=12, M=17) feeding incrementing bytes 0x00..0xFF wrapping, with a random in_valid duty cycle of about 60% → after 2244 accepted bytes, output equals the original sequence with no errors.
- Sync realign: continuous stream, assert in_sync with in_data = 0x47 when b = 5 → sync_err pulses once, the next byte is taken on branch 1, and out_branch = 0 for the 0x47 output cycle.
- Reset mid-stream: drop reset for 1 cycle after 500 bytes → all outputs = 0 immediately, the next accepted byte maps to branch 0, and branch outputs read 0x00 until refilled.
- With CONV_DEINT_PRIME_GATE_EN: continuous input → out_valid stays 0 for the first 2244 accepted bytes and first asserts on the output of byte 2245.
